// File: rtl/denorm_pkg.sv
// Shared types and constants for the iterative denormalizer.
package denorm_pkg;

  localparam int DEF_W     = 10;
  localparam int DEF_SW    = 5;
  localparam int EXT_W     = 2;
  localparam int MAX_SHIFT = DEF_W + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Beyond w+2 shifts every mantissa and extension bit already sits in sticky.
  function automatic int max_shift(input int w);
    return w + 2;
  endfunction

endpackage

// File: rtl/denorm_round_rne.sv
// Combinational round-to-nearest-even on a value with guard/round/sticky bits.
module round_rne
  import denorm_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] data_i,
  input  logic         g_i,
  input  logic         r_i,
  input  logic         s_i,
  output logic [W-1:0] val_o,
  output logic         inexact_o
);

  logic       inc;
  logic [W:0] sum;

  always_comb begin
    inc       = g_i & (r_i | s_i | data_i[0]);
    sum       = {1'b0, data_i} + {{W{1'b0}}, inc};
    // A carry out of the top bit saturates instead of wrapping to zero.
    val_o     = sum[W] ? {W{1'b1}} : sum[W-1:0];
    inexact_o = g_i | r_i | s_i;
  end

endmodule

// File: rtl/denorm_unit.sv
// Iterative denormalizer: right-shifts a normalized mantissa one bit per cycle,
// then rounds to nearest-even; valid/ready on both sides.
module denorm_unit
  import denorm_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int SW = DEF_SW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_mant,
  input  logic [SW-1:0]    in_shift,
  input  logic [EXT_W-1:0] in_ext,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_val,
  output logic             out_inexact
);

  localparam int            CW    = SW + 1;
  localparam logic [CW-1:0] CLAMP = CW'(max_shift(W));

  state_t        state_q, state_d;
  logic [W-1:0]  data_q, data_d;
  logic          g_q, g_d;
  logic          r_q, r_d;
  logic          s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  val_q, val_d;
  logic          inex_q, inex_d;

  logic [CW-1:0] shift_ext;
  logic [CW-1:0] shift_clamped;
  logic [W-1:0]  rnd_val;
  logic          rnd_inexact;

  assign shift_ext     = {1'b0, in_shift};
  assign shift_clamped = (shift_ext > CLAMP) ? CLAMP : shift_ext;

  round_rne #(.W(W)) u_round (
    .data_i    (data_q),
    .g_i       (g_q),
    .r_i       (r_q),
    .s_i       (s_q),
    .val_o     (rnd_val),
    .inexact_o (rnd_inexact)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    g_d     = g_q;
    r_d     = r_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    inex_d  = inex_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_mant;
          g_d     = in_ext[1];
          r_d     = in_ext[0];
          s_d     = 1'b0;
          cnt_d   = shift_clamped;
          state_d = (shift_clamped != '0) ? SHIFT : ROUND;
        end
      end
      SHIFT: begin
        // Bits fall through data -> guard -> round -> sticky.
        data_d = data_q >> 1;
        g_d    = data_q[0];
        r_d    = g_q;
        s_d    = s_q | r_q;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        val_d   = rnd_val;
        inex_d  = rnd_inexact;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      g_q     <= 1'b0;
      r_q     <= 1'b0;
      s_q     <= 1'b0;
      cnt_q   <= '0;
      val_q   <= '0;
      inex_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      g_q     <= g_d;
      r_q     <= r_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      inex_q  <= inex_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_val     = val_q;
  assign out_inexact = inex_q;

endmodule

// File: tb/tb_denorm_unit.sv
// Self-checking bench for denorm_unit: vector table, random requests through a
// scoreboard, backpressure and mid-operation reset.
module tb_denorm_unit;
  import denorm_pkg::*;

  localparam int W  = 10;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_mant;
  logic [SW-1:0] in_shift;
  logic [1:0]    in_ext;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_val;
  logic          out_inexact;

  always #5 clk = ~clk;

  denorm_unit #(.W(W), .SW(SW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mant     (in_mant),
    .in_shift    (in_shift),
    .in_ext      (in_ext),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_val     (out_val),
    .out_inexact (out_inexact)
  );

  typedef struct {
    logic [W-1:0]  mant;
    logic [SW-1:0] shift;
    logic [1:0]    ext;
    logic [W-1:0]  val;
    logic          inex;
    int            lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] val;
    logic         inex;
    int           lat;
  } exp_t;

  exp_t sb[$];
  vec_t vt[10];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: treat {mant,ext} as an integer, divide by 2^(n+2), round half to even.
  function automatic exp_t model(input logic [W-1:0] m, input logic [SW-1:0] sh, input logic [1:0] e);
    int     n;
    longint x, keep, rem, half;
    exp_t   r;
    n    = (int'(sh) > W + 2) ? W + 2 : int'(sh);
    x    = longint'({m, e});
    keep = x >> (n + 2);
    rem  = x & ((64'sd1 <<< (n + 2)) - 1);
    half = 64'sd1 <<< (n + 1);
    if (rem > half || (rem == half && keep[0])) keep = keep + 1;
    if (keep > (64'sd1 <<< W) - 1) keep = (64'sd1 <<< W) - 1;
    r.val  = keep[W-1:0];
    r.inex = (rem != 0);
    r.lat  = n + 1;
    return r;
  endfunction

  task automatic do_req(input string tag, input logic [W-1:0] m, input logic [SW-1:0] sh,
                        input logic [1:0] e, input exp_t ex, input int hold, input bit early);
    exp_t got;
    int   lat;
    check({tag, "_in_ready_idle"}, in_ready, 1);
    in_valid  = 1'b1;
    in_mant   = m;
    in_shift  = sh;
    in_ext    = e;
    out_ready = early;
    sb.push_back(ex);
    @(posedge clk); #1;
    check({tag, "_in_ready_busy"}, in_ready, 0);
    // Garbage offered while busy must be ignored.
    in_mant  = W'($urandom);
    in_shift = SW'($urandom);
    in_ext   = 2'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    got = sb.pop_front();
    if (!out_valid) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout actual=no_out_valid required=out_valid", tag);
      return;
    end
    check({tag, "_latency"}, lat, got.lat);
    check({tag, "_val"}, out_val, got.val);
    check({tag, "_inexact"}, out_inexact, got.inex);
    if (!early) begin
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        check({tag, "_hold_valid"}, out_valid, 1);
        check({tag, "_hold_val"}, {out_val, out_inexact}, {got.val, got.inex});
        check({tag, "_hold_in_ready"}, in_ready, 0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_post_valid"}, out_valid, 0);
    check({tag, "_post_in_ready"}, in_ready, 1);
    $display("txn %s mant=%h shift=%0d ext=%b -> val=%h inexact=%b lat=%0d", tag, m, sh, e, got.val, got.inex, lat);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t ex;
    int   seen;

    vt[0] = '{10'h200, 5'd3,  2'b00, 10'h040, 1'b0, 4};
    vt[1] = '{10'h3FF, 5'd1,  2'b00, 10'h200, 1'b1, 2};
    vt[2] = '{10'h005, 5'd1,  2'b00, 10'h002, 1'b1, 2};
    vt[3] = '{10'h007, 5'd1,  2'b00, 10'h004, 1'b1, 2};
    vt[4] = '{10'h3FF, 5'd31, 2'b00, 10'h000, 1'b1, 13};
    vt[5] = '{10'h3FF, 5'd0,  2'b10, 10'h3FF, 1'b1, 1};
    vt[6] = '{10'h000, 5'd5,  2'b11, 10'h000, 1'b1, 6};
    vt[7] = '{10'h000, 5'd0,  2'b00, 10'h000, 1'b0, 1};
    vt[8] = '{10'h155, 5'd12, 2'b01, 10'h000, 1'b1, 13};
    vt[9] = '{10'h2AB, 5'd2,  2'b01, 10'h0AB, 1'b1, 3};

    rst = 1'b1; in_valid = 1'b0; in_mant = '0; in_shift = '0; in_ext = '0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_val", out_val, 0);
    check("reset_out_inexact", out_inexact, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      ex.val = vt[i].val; ex.inex = vt[i].inex; ex.lat = vt[i].lat;
      do_req($sformatf("vec%0d", i), vt[i].mant, vt[i].shift, vt[i].ext, ex,
             (i == 0) ? 5 : 0, (i == 3 || i == 8));
    end

    for (int i = 0; i < 20; i++) begin
      logic [W-1:0]  m;
      logic [SW-1:0] sh;
      logic [1:0]    e;
      m  = W'($urandom);
      sh = SW'($urandom_range(0, 31));
      e  = 2'($urandom);
      do_req($sformatf("rnd%0d", i), m, sh, e, model(m, sh, e),
             $urandom_range(0, 2), bit'($urandom_range(0, 1)));
    end

    // Leave a nonzero result in the output register before the reset test.
    ex.val = vt[5].val; ex.inex = vt[5].inex; ex.lat = vt[5].lat;
    do_req("pre_reset", vt[5].mant, vt[5].shift, vt[5].ext, ex, 0, 1'b0);

    in_valid = 1'b1; in_mant = 10'h3FF; in_shift = 5'd8; in_ext = 2'b00;
    sb.push_back(model(10'h3FF, 5'd8, 2'b00));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midshift_in_ready", in_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_out_val", out_val, 0);
    check("rst_mid_out_inexact", out_inexact, 0);
    out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    check("rst_mid_no_output", seen, 0);
    $display("txn reset_mid_shift mant=3ff shift=8 dropped outputs_seen=%0d", seen);

    ex.val = vt[0].val; ex.inex = vt[0].inex; ex.lat = vt[0].lat;
    do_req("post_reset", vt[0].mant, vt[0].shift, vt[0].ext, ex, 1, 1'b0);

    check("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
